// File: rtl/serialtopar_align.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// Hunts for COMMA, confirms LOCK_CNT aligned commas, then delivers aligned words.
module serialtopar_align #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] COMMA    = WIDTH'(8'hBC),
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      ERR_CNT  = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_stb,
    output logic             lock
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(LOCK_CNT + 1);
    localparam int unsigned EW = $clog2(ERR_CNT + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t           state_q, state_d;
    // Only WIDTH-1 history bits are needed; the oldest bit falls off every cycle.
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] sr_next;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [CW-1:0]    ccnt_q, ccnt_d;
    logic [EW-1:0]    ecnt_q, ecnt_d;
    logic             misal_q, misal_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d, stb_d, lock_d;
    logic             boundary, is_comma;

    // Next-state and output decode
    always_comb begin
        sr_next  = {sr_q, data_in};
        boundary = (bcnt_q == BW'(WIDTH - 1));
        is_comma = (sr_next == COMMA);

        state_d = state_q;
        bcnt_d  = boundary ? '0 : bcnt_q + BW'(1);
        ccnt_d  = ccnt_q;
        ecnt_d  = ecnt_q;
        misal_d = misal_q;
        data_d  = data_out;
        valid_d = valid_out;
        stb_d   = 1'b0;

        case (state_q)
            HUNT: begin
                bcnt_d = '0;
                if (is_comma) begin
                    ccnt_d  = CW'(1);
                    state_d = (LOCK_CNT == 1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    stb_d = 1'b1;
                    if (is_comma) begin
                        if (32'(ccnt_q) + 32'd1 >= LOCK_CNT) begin
                            ccnt_d  = CW'(LOCK_CNT);
                            state_d = LOCKED;
                        end else begin
                            ccnt_d = ccnt_q + CW'(1);
                        end
                    end else begin
                        ccnt_d  = '0;
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                // Error threshold reached on the previous boundary: drop lock now.
                if (32'(ecnt_q) >= ERR_CNT) begin
                    state_d = HUNT;
                    bcnt_d  = '0;
                    ccnt_d  = '0;
                    ecnt_d  = '0;
                    misal_d = 1'b0;
                    valid_d = 1'b0;
                end else if (boundary) begin
                    stb_d   = 1'b1;
                    data_d  = sr_next;
                    valid_d = !is_comma;
                    if (is_comma) begin
                        ecnt_d  = '0;
                        misal_d = 1'b0;
                    end else if (misal_q) begin
                        if (32'(ecnt_q) < ERR_CNT) begin
                            ecnt_d = ecnt_q + EW'(1);
                        end
                        misal_d = 1'b0;
                    end
                end else if (is_comma) begin
                    misal_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
                bcnt_d  = '0;
            end
        endcase

        lock_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            bcnt_q    <= '0;
            ccnt_q    <= '0;
            ecnt_q    <= '0;
            misal_q   <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            word_stb  <= 1'b0;
            lock      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_next[WIDTH-2:0];
            bcnt_q    <= bcnt_d;
            ccnt_q    <= ccnt_d;
            ecnt_q    <= ecnt_d;
            misal_q   <= misal_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            word_stb  <= stb_d;
            lock      <= lock_d;
        end
    end

endmodule

// File: doc/serialtopar_align.md
SERIALTOPAR_ALIGN -- requirements
Module: serialtopar_align

Interface
REQ-001 SHALL have parameter WIDTH, default 8, deserialized word width (legal 4..32).
REQ-002 SHALL have parameter COMMA, default 8'hBC (WIDTH bits), alignment/idle symbol.
REQ-003 SHALL have parameter LOCK_CNT, default 4, consecutive aligned commas required to lock (legal 1..15).
REQ-004 SHALL have parameter ERR_CNT, default 2, consecutive misaligned-comma word periods that force loss of lock (legal 1..15).
REQ-005 SHALL have port clk  input  1  bit-rate clock; all state on posedge.
REQ-006 SHALL have port reset_L  input  1  asynchronous active-low reset.
REQ-007 SHALL have port data_in  input  1  serial data, MSB of each word first.
REQ-008 SHALL have port data_out  output  WIDTH  last complete aligned word, registered.
REQ-009 SHALL have port valid_out  output  1  high while data_out holds a non-comma word received in LOCKED.
REQ-010 SHALL have port word_stb  output  1  one-cycle pulse per word boundary while in SYNC or LOCKED.
REQ-011 SHALL have port lock  output  1  high while state is LOCKED.

Function
REQ-012 SHALL form sr_next = {sr[WIDTH-2:0], data_in} each cycle and register it as sr; all comparisons use sr_next.
REQ-013 SHALL implement states HUNT, SYNC, LOCKED, with a bit counter bcnt (0..WIDTH-1) and counters ccnt (aligned commas) and ecnt (errors).
REQ-014 In HUNT, on the cycle sr_next == COMMA, SHALL treat that edge as a word boundary, set bcnt=0, ccnt=1, and go to SYNC (or directly to LOCKED if LOCK_CNT==1).
REQ-015 In SYNC and LOCKED, bcnt SHALL increment each cycle and wrap WIDTH-1 -> 0; a boundary is the edge where bcnt wraps to 0.
REQ-016 In SYNC at a boundary: sr_next == COMMA increments ccnt, and reaching LOCK_CNT enters LOCKED; any other word returns to HUNT with ccnt=0.
REQ-017 In SYNC, non-boundary comma matches SHALL be ignored.
REQ-018 In LOCKED at every boundary, SHALL load data_out <= sr_next, set valid_out <= (sr_next != COMMA), and pulse word_stb.
REQ-019 valid_out SHALL hold its value until the next boundary or until LOCKED is exited.
REQ-020 In LOCKED, SHALL set a sticky flag misal on any non-boundary cycle with sr_next == COMMA.
REQ-021 At each LOCKED boundary: an aligned comma clears ecnt and misal; otherwise, if misal is set, increment ecnt and clear misal; otherwise hold ecnt.
REQ-022 An aligned comma SHALL take priority over misal when both occur in the same word period.
REQ-023 When ecnt reaches ERR_CNT, SHALL go to HUNT the next edge and clear valid_out, lock, ccnt, and ecnt; data_out holds its value.
REQ-024 word_stb SHALL also pulse at SYNC boundaries; data_out and valid_out SHALL NOT change outside LOCKED boundaries.
REQ-025 Latency: data_out and valid_out SHALL be visible the cycle after the edge sampling the word's last bit.
REQ-026 Counters SHALL be sized $clog2 of their maximum and SHALL saturate, never wrap.

Reset
REQ-027 reset_L low SHALL immediately, without a clock edge, set data_out=0, valid_out=0, word_stb=0, lock=0, sr=0, bcnt=ccnt=ecnt=0, misal=0, and state HUNT.
REQ-028 Reset asserted mid-word or while locked SHALL discard the partial word; after release, the block SHALL search from HUNT.

Verification (WIDTH=8, COMMA=BC, LOCK_CNT=4, ERR_CNT=2 unless stated)
REQ-029 3 garbage bits, then 4×BC, then A5 -> lock=1 after the 4th BC; next word gives data_out=A5, valid_out=1, and one word_stb pulse.
REQ-030 3×BC, then 12 -> lock stays 0, state returns to HUNT, valid_out=0 throughout.
REQ-031 Locked, stream A5,BC,3C -> data_out A5/BC/3C; valid_out 1/0/1; lock stays 1.
REQ-032 Locked, insert 1 extra bit, then continuous BC -> lock drops after 2 misaligned word periods, then relocks at the new phase after 4 aligned BC.
REQ-033 Locked, reset_L pulsed low between clock edges -> all outputs 0 immediately; after release, needs 4×BC to relock.
REQ-034 LOCK_CNT=1, single BC then 55 -> lock=1 at the BC boundary; next word data_out=55, valid_out=1.
